// File: rtl/tmp101_guard_pkg.sv
// Shared types, widths and the duty saturation helper for the TMP101 thermal guard.
package tmp101_guard_pkg;

  localparam int unsigned TempWidth = 12;
  localparam int unsigned DutyWidth = 8;
  localparam logic [DutyWidth-1:0] DutyMax = 8'hFF;

  typedef enum logic [1:0] {
    StNormal   = 2'd0,
    StWarn     = 2'd1,
    StShutdown = 2'd2,
    StFault    = 2'd3
  } guard_state_e;

  // diff is one bit wider than the temperature so (t - T_FAN_LO) never wraps.
  function automatic logic [DutyWidth-1:0] sat_duty(input logic signed [TempWidth:0] diff,
                                                     input int unsigned shift);
    logic signed [TempWidth:0] shifted;
    shifted = diff >>> shift;
    if (shifted <= 13'sd0) begin
      return '0;
    end
    if (shifted > 13'sd255) begin
      return DutyMax;
    end
    return shifted[DutyWidth-1:0];
  endfunction

endpackage

// File: rtl/tmp101_thermal_guard_if.sv
// Sensor-side inputs and protection outputs of the TMP101 thermal guard.
interface tmp101_thermal_guard_if;
  import tmp101_guard_pkg::*;

  logic                 ena;
  logic [TempWidth-1:0] temperature;
  logic [2:0]           status;
  logic                 clear;
  logic                 fan_pwm;
  logic [DutyWidth-1:0] duty;
  logic                 warn;
  logic                 shutdown;
  logic                 sensor_fault;
  logic [1:0]           state;

  modport master (
    output ena, temperature, status, clear,
    input  fan_pwm, duty, warn, shutdown, sensor_fault, state
  );

  modport slave (
    input  ena, temperature, status, clear,
    output fan_pwm, duty, warn, shutdown, sensor_fault, state
  );

endinterface

// File: rtl/fan_pwm_gen.sv
// Fan PWM: prescaled 8-bit phase counter; duty reloads only at the phase wrap.
module fan_pwm_gen
  import tmp101_guard_pkg::*;
#(
  parameter int unsigned PWM_DIV = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DutyWidth-1:0] duty_target,
  output logic [DutyWidth-1:0] duty,
  output logic                 fan_pwm
);

  localparam int unsigned DivW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DivW-1:0]      div_q, div_d;
  logic [DutyWidth-1:0] phase_q, phase_d;
  logic [DutyWidth-1:0] duty_q, duty_d;
  logic                 pwm_q;
  logic                 tick;

  assign tick = (div_q == DivW'(PWM_DIV - 1));

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    phase_d = tick ? phase_q + 1'b1 : phase_q;
    duty_d  = (tick && (phase_q == DutyMax)) ? duty_target : duty_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q   <= '0;
      phase_q <= '0;
      duty_q  <= DutyMax;
      pwm_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      // Full-scale duty must be solid on; phase < 255 alone would leave one low slot.
      pwm_q   <= (duty_d == DutyMax) || (phase_d < duty_d);
    end
  end

  assign duty    = duty_q;
  assign fan_pwm = pwm_q;

endmodule

// File: rtl/tmp101_thermal_guard.sv
// Thermal guard: debounced warn/shutdown FSM with hysteresis, stale-sensor fault, fan PWM.
module tmp101_thermal_guard
  import tmp101_guard_pkg::*;
#(
  parameter int unsigned FREQ_CLK     = 100_000_000,
  parameter int unsigned PWM_FREQ     = 25_000,
  parameter int          T_FAN_LO     = 480,
  parameter int unsigned FAN_SHIFT    = 1,
  parameter int          T_WARN       = 1120,
  parameter int          T_SHUT       = 1360,
  parameter int          T_HYST       = 80,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned STALE_CYC    = 200_000_000
) (
  input logic                   clk,
  input logic                   reset_n,
  tmp101_thermal_guard_if.slave bus
);

  localparam int unsigned PwmDivRaw = FREQ_CLK / (PWM_FREQ * 256);
  localparam int unsigned PwmDiv    = (PwmDivRaw < 1) ? 1 : PwmDivRaw;
  localparam int unsigned DbW       = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned StW       = $clog2(STALE_CYC + 1);

  localparam logic signed [TempWidth:0] TFanLoW = 13'(T_FAN_LO);
  localparam logic signed [TempWidth:0] TWarnW  = 13'(T_WARN);
  localparam logic signed [TempWidth:0] TShutW  = 13'(T_SHUT);
  localparam logic signed [TempWidth:0] TCoolW  = 13'(T_WARN - T_HYST);
  localparam logic signed [TempWidth:0] TRelW   = 13'(T_SHUT - T_HYST);

  localparam logic [DbW-1:0] DebLast  = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [StW-1:0] StaleMax = StW'(STALE_CYC);

  guard_state_e state_q, state_d;
  logic [DbW-1:0] deb_q, deb_d;
  logic [StW-1:0] stale_q, stale_d;
  logic           fault_q, warn_q, shut_q;

  logic                        v;
  logic signed [TempWidth:0]   t_w;
  logic                        hot_warn, hot_shut, cool_warn, clear_ok;
  logic                        deb_cond, deb_done, stale_full;
  logic [DutyWidth-1:0]        duty_target;
  logic [DutyWidth-1:0]        duty;
  logic                        fan_pwm;
  logic                        unused_status;

  assign v             = bus.status[0];
  assign unused_status = ^bus.status[2:1];
  assign t_w           = signed'({bus.temperature[TempWidth-1], bus.temperature});

  assign hot_warn  = v && (t_w >= TWarnW);
  assign hot_shut  = v && (t_w >= TShutW);
  assign cool_warn = v && (t_w < TCoolW);
  assign clear_ok  = v && (t_w < TRelW);

  always_comb begin
    deb_cond = 1'b0;
    unique case (state_q)
      StNormal:   deb_cond = hot_warn;
      StWarn:     deb_cond = hot_shut || cool_warn;
      StShutdown: deb_cond = 1'b0;
      StFault:    deb_cond = 1'b0;
    endcase
  end

  assign deb_done = deb_cond && (deb_q == DebLast);
  // Any state change either comes from deb_done or happens where deb_cond is 0.
  assign deb_d    = (deb_cond && !deb_done) ? deb_q + 1'b1 : '0;

  always_comb begin
    if (v) begin
      stale_d = '0;
    end else if (stale_q == StaleMax) begin
      stale_d = stale_q;
    end else begin
      stale_d = stale_q + 1'b1;
    end
  end

  assign stale_full = (stale_d == StaleMax);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNormal: begin
        if (stale_full) begin
          state_d = StFault;
        end else if (deb_done) begin
          state_d = hot_shut ? StShutdown : StWarn;
        end
      end
      StWarn: begin
        if (stale_full) begin
          state_d = StFault;
        end else if (deb_done) begin
          state_d = hot_shut ? StShutdown : StNormal;
        end
      end
      StShutdown: begin
        if (bus.clear && clear_ok) begin
          state_d = StNormal;
        end
      end
      StFault: begin
        if (v) begin
          state_d = StNormal;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StNormal;
      deb_q   <= '0;
      stale_q <= '0;
      fault_q <= 1'b0;
      warn_q  <= 1'b0;
      shut_q  <= 1'b0;
    end else if (bus.ena) begin
      state_q <= state_d;
      deb_q   <= deb_d;
      stale_q <= stale_d;
      fault_q <= stale_full;
      warn_q  <= (state_d == StWarn) || (state_d == StShutdown);
      shut_q  <= (state_d == StShutdown);
    end
  end

  // Fail-safe full fan whenever the reading is missing or protection is active.
  always_comb begin
    if (!v || (state_q inside {StShutdown, StFault})) begin
      duty_target = DutyMax;
    end else if (t_w <= TFanLoW) begin
      duty_target = '0;
    end else begin
      duty_target = sat_duty(t_w - TFanLoW, FAN_SHIFT);
    end
  end

  fan_pwm_gen #(
    .PWM_DIV(PwmDiv)
  ) u_fan_pwm_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .duty_target(duty_target),
    .duty       (duty),
    .fan_pwm    (fan_pwm)
  );

  assign bus.duty         = duty;
  assign bus.fan_pwm      = fan_pwm;
  assign bus.state        = state_q;
  assign bus.warn         = warn_q;
  assign bus.shutdown     = shut_q;
  assign bus.sensor_fault = fault_q;

endmodule

// File: tb/tb_tmp101_thermal_guard.sv
// Directed scoreboard bench for tmp101_thermal_guard (PWM_DIV=1, debounce 16, stale 64).
module tb_tmp101_thermal_guard;
  import tmp101_guard_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  tmp101_thermal_guard_if bus ();

  tmp101_thermal_guard #(
    .FREQ_CLK    (2560),
    .PWM_FREQ    (10),
    .DEBOUNCE_CYC(16),
    .STALE_CYC   (64)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic wait_duty(input logic [7:0] target, input int limit);
    for (int i = 0; i < limit && bus.duty !== target; i++) tick(1);
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.fan_pwm === 1'b1) cnt++;
      tick(1);
    end
  endtask

  initial begin
    int cnt;
    reset_n         = 1'b0;
    bus.ena         = 1'b1;
    bus.temperature = 12'd400;
    bus.status      = 3'b001;
    bus.clear       = 1'b0;
    tick(3);
    expect_val("rst_state", 0);    check(32'(bus.state));
    expect_val("rst_duty", 255);   check(32'(bus.duty));
    expect_val("rst_fan", 0);      check(32'(bus.fan_pwm));
    expect_val("rst_flags", 0);    check(32'({bus.warn, bus.shutdown, bus.sensor_fault}));

    reset_n = 1'b1;
    tick(1);
    expect_val("fan_first_cycle", 1); check(32'(bus.fan_pwm));
    expect_val("state_t400", 0);      check(32'(bus.state));

    // Step 1: cool sensor -> duty 0 at first wrap
    expect_val("duty_t400", 0);
    wait_duty(8'd0, 300);
    check(32'(bus.duty));
    expect_val("highs_t400", 0);
    count_high(256, cnt);
    check(32'(cnt));

    // Step 2: t=720 -> (240>>1)=120
    bus.temperature = 12'd720;
    expect_val("duty_t720", 120);
    wait_duty(8'd120, 300);
    check(32'(bus.duty));
    expect_val("highs_t720", 120);
    count_high(256, cnt);
    check(32'(cnt));

    // Step 3: warn debounce and hysteresis
    bus.temperature = 12'd1120;
    tick(15);
    expect_val("warn_15_state", 0); check(32'(bus.state));
    bus.temperature = 12'd1000;
    tick(1);
    bus.temperature = 12'd1120;
    tick(15);
    expect_val("warn_early", 0);    check(32'(bus.warn));
    tick(1);
    expect_val("warn_at_16", 1);    check(32'(bus.warn));
    expect_val("state_warn", 1);    check(32'(bus.state));
    bus.temperature = 12'd1041;
    tick(20);
    expect_val("hyst_1041", 1);     check(32'(bus.state));
    bus.temperature = 12'd1039;
    tick(15);
    expect_val("cool_15", 1);       check(32'(bus.state));
    tick(1);
    expect_val("cool_16_state", 0); check(32'(bus.state));
    expect_val("cool_16_warn", 0);  check(32'(bus.warn));

    // Step 4: shutdown, latched until a valid clear
    bus.temperature = 12'd1400;
    tick(15);
    expect_val("shut_15", 0);       check(32'(bus.state));
    tick(1);
    expect_val("shut_16_state", 2); check(32'(bus.state));
    expect_val("shut_16_flags", 3); check(32'({bus.warn, bus.shutdown}));
    expect_val("shut_duty", 255);
    wait_duty(8'd255, 300);
    check(32'(bus.duty));
    expect_val("shut_highs", 256);
    count_high(256, cnt);
    check(32'(cnt));
    bus.temperature = 12'd1300;
    bus.clear       = 1'b1;
    tick(1);
    bus.clear       = 1'b0;
    expect_val("clear_hot", 2);     check(32'(bus.state));
    bus.temperature = 12'd1270;
    bus.status      = 3'b000;
    bus.clear       = 1'b1;
    tick(1);
    bus.status      = 3'b001;
    bus.clear       = 1'b0;
    expect_val("clear_invalid", 2); check(32'(bus.state));
    bus.clear       = 1'b1;
    tick(1);
    bus.clear       = 1'b0;
    expect_val("clear_ok_state", 0); check(32'(bus.state));
    expect_val("clear_ok_shut", 0);  check(32'(bus.shutdown));

    // Step 5: stale sensor
    bus.temperature = 12'd400;
    tick(2);
    bus.status = 3'b000;
    tick(63);
    expect_val("stale_63_fault", 0); check(32'(bus.sensor_fault));
    expect_val("stale_63_state", 0); check(32'(bus.state));
    bus.status = 3'b001;
    tick(1);
    bus.status = 3'b000;
    tick(64);
    expect_val("stale_64_fault", 1); check(32'(bus.sensor_fault));
    expect_val("stale_64_state", 3); check(32'(bus.state));
    expect_val("stale_duty", 255);
    wait_duty(8'd255, 300);
    check(32'(bus.duty));
    bus.status = 3'b001;
    tick(1);
    expect_val("fault_exit_state", 0); check(32'(bus.state));
    expect_val("fault_exit_flag", 0);  check(32'(bus.sensor_fault));

    // ena=0 freezes the debounce count mid-way
    bus.temperature = 12'd1120;
    tick(10);
    bus.ena = 1'b0;
    tick(30);
    expect_val("ena_hold", 0);      check(32'(bus.state));
    bus.ena = 1'b1;
    tick(5);
    expect_val("ena_resume_15", 0); check(32'(bus.state));
    tick(1);
    expect_val("ena_resume_16", 1); check(32'(bus.state));

    // Step 6: reset mid-WARN with a pending cool-down count
    bus.temperature = 12'd1039;
    tick(8);
    reset_n = 1'b0;
    tick(1);
    expect_val("rst2_state", 0);  check(32'(bus.state));
    expect_val("rst2_flags", 0);  check(32'({bus.warn, bus.shutdown, bus.sensor_fault}));
    expect_val("rst2_duty", 255); check(32'(bus.duty));
    expect_val("rst2_fan", 0);    check(32'(bus.fan_pwm));
    reset_n         = 1'b1;
    bus.temperature = 12'd1120;
    tick(15);
    expect_val("rst2_warn_15", 0); check(32'(bus.state));
    tick(1);
    expect_val("rst2_warn_16", 1); check(32'(bus.state));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tmp101_thermal_guard.md
# tmp101_thermal_guard

- Thermal-protection stage downstream of the TMP101 sensor reader in the DE0_CV servo design.
- Consumes the reader's 12-bit temperature word and its `{i2c_busy, ack_error, data_valid}` status.
- Applies debounced warning/shutdown thresholds with hysteresis, detects a stale sensor, and drives a fail-safe fan PWM.

## Interface
Parameters:
- FREQ_CLK, 100_000_000, clk frequency in Hz
- PWM_FREQ, 25_000, target fan PWM frequency; PWM_DIV = max(1, FREQ_CLK/(PWM_FREQ*256))
- T_FAN_LO, 480, signed 12-bit, 30 °C; duty is 0 at or below this
- FAN_SHIFT, 1, duty = (t − T_FAN_LO) >> FAN_SHIFT, saturated to 0..255
- T_WARN, 1120, 70 °C warning threshold
- T_SHUT, 1360, 85 °C shutdown threshold
- T_HYST, 80, 5 °C hysteresis
- DEBOUNCE_CYC, 1_000_000, consecutive cycles a threshold condition must hold
- STALE_CYC, 200_000_000, consecutive cycles of data_valid=0 that declare a sensor fault

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- ena  in  1  when 0, FSM, debounce and stale counters freeze; PWM keeps running
- temperature  in  12  signed two's complement, 0.0625 °C/LSB
- status  in  3  {i2c_busy, ack_error, data_valid}; only bit 0 is used
- clear  in  1  single-cycle request to release a latched shutdown
- fan_pwm  out  1  fan drive, registered
- duty  out  8  duty currently applied
- warn  out  1  state is WARN or SHUTDOWN
- shutdown  out  1  state is SHUTDOWN
- sensor_fault  out  1  stale flag
- state  out  2  NORMAL=0, WARN=1, SHUTDOWN=2, FAULT=3

## Operation
- Let v = status[0] and t = temperature. All comparisons are signed and evaluated only while v=1.
- **Debounce counter:** counts consecutive cycles in which the current state's exit condition holds. It clears when the condition drops, when v=0, or on any state change.
- **NORMAL → SHUTDOWN:** t ≥ T_SHUT for DEBOUNCE_CYC cycles. Takes priority over WARN.
- **NORMAL → WARN:** t ≥ T_WARN for DEBOUNCE_CYC cycles.
- **WARN → SHUTDOWN:** t ≥ T_SHUT, debounced.
- **WARN → NORMAL:** t < T_WARN − T_HYST, debounced.
- **SHUTDOWN:** latched. Exits to NORMAL only when clear=1, v=1 and t < T_SHUT − T_HYST in the same cycle. A clear under any other condition is ignored.
- **Stale counter:** counts cycles with v=0 and clears when v=1.
  - On reaching STALE_CYC, sensor_fault=1.
  - NORMAL or WARN then move to FAULT. SHUTDOWN stays SHUTDOWN.
- **FAULT → NORMAL:** the first cycle v=1; sensor_fault clears in the same cycle.
- **Duty target:**
  - 255 when v=0 or state is SHUTDOWN/FAULT (fail-safe).
  - Otherwise 0 when t ≤ T_FAN_LO.
  - Otherwise the shifted difference, saturated at 255. Compute in 13 bits so nothing wraps.
- **PWM:**
  - Divider ticks every PWM_DIV cycles; the 8-bit phase increments per tick and wraps 255→0.
  - The duty register loads the target only on the tick where phase wraps to 0 (glitch-free).
  - fan_pwm = (phase < duty), except duty=255 forces 1.

## Timing
- **Reset values:** state=NORMAL; debounce, stale, divider and phase counters = 0; duty=255; fan_pwm=0; warn=shutdown=sensor_fault=0.
- The first cycle after reset release registers fan_pwm=1.
- A condition first true in cycle n gives a state change visible in cycle n+DEBOUNCE_CYC.
- warn, shutdown and state decode directly from the state register; no extra latency.
- FAULT is entered STALE_CYC cycles after v first falls.
- A duty change is seen on fan_pwm at the next phase wrap, at most 256·PWM_DIV cycles later.
- **Simultaneous events:**
  - SHUTDOWN beats WARN.
  - Stale beats debounce.
  - clear in the same cycle as a shutdown entry has no effect.
- **ena=0:** outputs hold, except fan_pwm/duty, which keep following the PWM.
- **reset_n low mid-operation:** all state returns to reset values on the next edge.

## Structure
- Package tmp101_guard_pkg:
  - state enum and its encodings
  - 12-bit temperature/duty width constants
  - saturating duty function
- Sub-module fan_pwm_gen: divider, phase counter, duty load at wrap, duty=255 override.
- Top level holds the FSM, debounce counter and stale counter.

## Test plan
Bench parameters: FREQ_CLK=2560, PWM_FREQ=10 (PWM_DIV=1), DEBOUNCE_CYC=16, STALE_CYC=64.
1. Reset, then v=1 with t=400 → state 0; duty becomes 0 at the first wrap; fan_pwm=0 thereafter.
2. t=720 → duty=120; fan_pwm high for 120 of every 256 cycles.
3. t=1120 held 15 cycles then dropped to 1000 → no WARN. Then t=1120 held 16 cycles → warn=1 exactly at cycle 16. Then t=1041 → stays WARN; t=1039 for 16 cycles → NORMAL.
4. t=1400 for 16 cycles → shutdown=1, duty=255.
   - clear with t=1300 → still SHUTDOWN.
   - clear with t=1270 → NORMAL next cycle.
5. v=0 for 63 cycles → no fault; v=0 for 64 cycles → sensor_fault=1, state 3, duty=255; v=1 → NORMAL.
6. reset_n low during WARN with a debounce count pending → all outputs at reset values; t=1120 requires a full 16 fresh cycles.
